// File: rtl/codec_i2c_seq.sv
// Codec register-write sequencer: splits one command into three I2C bytes for the byte engine.
// Optional NACK retry is built in when the macro CODEC_I2C_RETRY_EN is defined.
module codec_i2c_seq #(
  parameter logic [15:0] C_CLK_DIVISOR = 16'd2,
  parameter logic [15:0] C_GAP_CYCLES  = 16'd4
`ifdef CODEC_I2C_RETRY_EN
  ,
  parameter logic [1:0]  C_MAX_RETRY   = 2'd3
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_dev_addr,
  input  logic [6:0] cmd_reg_addr,
  input  logic [8:0] cmd_reg_data,
  output logic [1:0] eng_op,
  output logic [7:0] eng_wdata,
  input  logic       eng_ack,
  output logic       busy,
  output logic       done,
  output logic       nack
);

  localparam logic [19:0] XFER_LAST = 20'(9 * 32'(C_CLK_DIVISOR) - 1);
  localparam logic [15:0] GAP_LAST  = C_GAP_CYCLES - 16'd1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_XFER, S_GAP} state_t;

  state_t      state, state_nxt;
  logic [6:0]  dev_q, reg_q;
  logic [8:0]  data_q;
  logic [1:0]  idx;
  logic [19:0] xfer_cnt;
  logic [15:0] gap_cnt;
  logic        ack_seen, nack_flag;
  logic        xfer_end, gap_end, ack_ok, retry_ok;
  logic        accept, next_byte, retry_go, finish;

  // The engine shifts LSB first, so the byte is mirrored to put its MSB on the wire first.
  function automatic logic [7:0] bit_rev(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [7:0] byte_sel(input logic [1:0] i, input logic [6:0] dev,
                                          input logic [6:0] ra, input logic [8:0] rd);
    case (i)
      2'd0:    return {dev, 1'b0};
      2'd1:    return {ra, rd[8]};
      default: return rd[7:0];
    endcase
  endfunction

  assign xfer_end  = (state == S_XFER) && (xfer_cnt == XFER_LAST);
  assign gap_end   = (state == S_GAP) && (gap_cnt == GAP_LAST);
  assign ack_ok    = ack_seen || eng_ack;
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign eng_op    = (state == S_XFER) ? 2'd1 : 2'd0;

`ifdef CODEC_I2C_RETRY_EN
  logic [1:0] retry_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           retry_cnt <= 2'd0;
    else if (accept)   retry_cnt <= 2'd0;
    else if (retry_go) retry_cnt <= retry_cnt + 2'd1;
  end

  assign retry_ok = nack_flag && (retry_cnt < C_MAX_RETRY);
`else
  assign retry_ok = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    next_byte = 1'b0;
    retry_go  = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: state_nxt = S_XFER;
      S_XFER: begin
        if (xfer_end) begin
          if (ack_ok && (idx != 2'd2)) begin
            next_byte = 1'b1;
            state_nxt = S_LOAD;
          end else begin
            state_nxt = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_end) begin
          if (retry_ok) begin
            retry_go  = 1'b1;
            state_nxt = S_LOAD;
          end else begin
            finish    = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A NACK on any byte skips the remaining bytes and is reported with the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dev_q     <= 7'd0;
      reg_q     <= 7'd0;
      data_q    <= 9'd0;
      idx       <= 2'd0;
      xfer_cnt  <= 20'd0;
      gap_cnt   <= 16'd0;
      ack_seen  <= 1'b0;
      nack_flag <= 1'b0;
      eng_wdata <= 8'd0;
      done      <= 1'b0;
      nack      <= 1'b0;
    end else begin
      done     <= finish;
      nack     <= finish && nack_flag;
      xfer_cnt <= (state == S_XFER) ? xfer_cnt + 20'd1 : 20'd0;
      gap_cnt  <= (state == S_GAP) ? gap_cnt + 16'd1 : 16'd0;
      if (state == S_LOAD)
        ack_seen <= 1'b0;
      else if ((state == S_XFER) && eng_ack)
        ack_seen <= 1'b1;
      if (accept) begin
        dev_q     <= cmd_dev_addr;
        reg_q     <= cmd_reg_addr;
        data_q    <= cmd_reg_data;
        idx       <= 2'd0;
        nack_flag <= 1'b0;
        eng_wdata <= bit_rev({cmd_dev_addr, 1'b0});
      end else if (next_byte) begin
        idx       <= idx + 2'd1;
        eng_wdata <= bit_rev(byte_sel(idx + 2'd1, dev_q, reg_q, data_q));
      end else if (retry_go) begin
        idx       <= 2'd0;
        nack_flag <= 1'b0;
        eng_wdata <= bit_rev(byte_sel(2'd0, dev_q, reg_q, data_q));
      end else if (xfer_end && !ack_ok) begin
        nack_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_codec_i2c_seq.sv
// Scoreboard bench for codec_i2c_seq: a command-level model predicts bytes, latency and status,
// an engine responder plays out per-byte ACK/NACK, and a monitor checks every done pulse.
module tb_codec_i2c_seq;

  localparam int DIV      = 2;
  localparam int GAP      = 4;
  localparam int XFER_LEN = 9 * DIV;
`ifdef CODEC_I2C_RETRY_EN
  localparam int RETRY     = 1;
`else
  localparam int RETRY     = 0;
`endif
  localparam int MAX_RETRY = 3;

  logic       clk, rst;
  logic       cmd_valid, cmd_ready;
  logic [6:0] cmd_dev_addr, cmd_reg_addr;
  logic [8:0] cmd_reg_data;
  logic [1:0] eng_op;
  logic [7:0] eng_wdata;
  logic       eng_ack, busy, done, nack;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  bit         run_q[$];
  logic [7:0] obs[$];
  logic [7:0] exp_bytes_q[$];
  int         exp_nack_q[$], exp_lat_q[$], exp_nb_q[$], acc_q[$];

  codec_i2c_seq dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_reg_data(cmd_reg_data),
    .eng_op(eng_op), .eng_wdata(eng_wdata), .eng_ack(eng_ack),
    .busy(busy), .done(done), .nack(nack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Command-level model: each XFER run consumes the next ACK bit; a NACK ends the attempt.
  task automatic applyStimulus(input logic [6:0] dev, input logic [6:0] ra,
                               input logic [8:0] rd, input logic [11:0] acks);
    logic [7:0] b [3];
    logic [7:0] raw;
    int runs, attempts, w;
    bit nk;
    raw = {dev, 1'b0};  b[0] = {<<{raw}};
    raw = {ra, rd[8]};  b[1] = {<<{raw}};
    raw = rd[7:0];      b[2] = {<<{raw}};
    runs = 0;
    attempts = 0;
    do begin
      attempts++;
      nk = 1'b0;
      for (int i = 0; i < 3; i++) begin
        exp_bytes_q.push_back(b[i]);
        run_q.push_back(acks[runs]);
        runs++;
        if (!acks[runs-1]) begin
          nk = 1'b1;
          break;
        end
      end
    end while (nk && (RETRY != 0) && (attempts <= MAX_RETRY));
    exp_nack_q.push_back(int'(nk));
    exp_lat_q.push_back(runs * (1 + XFER_LEN) + attempts * GAP);
    exp_nb_q.push_back(runs);

    cmd_dev_addr = dev;
    cmd_reg_addr = ra;
    cmd_reg_data = rd;
    cmd_valid    = 1'b1;
    for (w = 0; w < 3000; w++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    if (w == 3000) checkOutput("accept_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    for (int w = 0; w < 5000 && exp_nack_q.size() != 0; w++) begin
      @(posedge clk);
      #1;
    end
    if (exp_nack_q.size() != 0) checkOutput("drain_timeout", exp_nack_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Engine responder: pulses eng_ack once in the ack slot of ACKed bytes, noise outside XFER.
  initial begin
    bit r_in, r_ack;
    int r_cnt, r_pos;
    r_in = 1'b0; r_ack = 1'b0; r_cnt = 0; r_pos = 0;
    eng_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        r_in = 1'b0;
        eng_ack = 1'b0;
      end else if (eng_op == 2'd1) begin
        if (!r_in) begin
          r_in  = 1'b1;
          r_cnt = 0;
          r_ack = (run_q.size() > 0) ? run_q.pop_front() : 1'b0;
          r_pos = 8 * DIV + $urandom_range(DIV - 1, 0);
        end else begin
          r_cnt++;
        end
        eng_ack = r_ack && (r_cnt == r_pos);
      end else begin
        r_in = 1'b0;
        eng_ack = ($urandom_range(7, 0) == 0);
      end
    end
  end

  // Monitor: collects bytes per XFER run and pops the scoreboard on every done pulse.
  initial begin
    bit m_in;
    int m_len, e_n, e_l, e_nb, a;
    logic [7:0] eb;
    m_in = 1'b0; m_len = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        obs.delete();
        m_in = 1'b0;
        m_len = 0;
      end else begin
        if (eng_op == 2'd1) begin
          if (!m_in) begin
            obs.push_back(eng_wdata);
            m_len = 0;
          end
          m_in = 1'b1;
          m_len++;
        end else begin
          if (m_in) checkOutput("xfer_len", m_len, XFER_LEN);
          m_in = 1'b0;
          m_len = 0;
        end
        if (nack && !done) checkOutput("nack_without_done", 1, 0);
        if (done) begin
          done_cnt++;
          if (exp_nack_q.size() == 0) begin
            checkOutput("unexpected_done", 1, 0);
          end else begin
            e_n  = exp_nack_q.pop_front();
            e_l  = exp_lat_q.pop_front();
            e_nb = exp_nb_q.pop_front();
            a    = (acc_q.size() > 0) ? acc_q.pop_front() : -100000;
            checkOutput("nack", nack, e_n);
            checkOutput("latency", cyc - a, e_l);
            checkOutput("byte_count", obs.size(), e_nb);
            checkOutput("busy_at_done", busy, 0);
            checkOutput("ready_at_done", cmd_ready, 1);
            for (int i = 0; i < e_nb; i++) begin
              eb = exp_bytes_q.pop_front();
              if (i < obs.size()) checkOutput("wdata_byte", obs[i], eb);
            end
          end
          obs.delete();
        end
        if (cmd_valid && cmd_ready) acc_q.push_back(cyc + 1);
      end
    end
  end

  task automatic resetMidXfer();
    int w, d0;
    run_q.push_back(1'b1);
    run_q.push_back(1'b1);
    run_q.push_back(1'b1);
    cmd_dev_addr = 7'h1A;
    cmd_reg_addr = 7'h06;
    cmd_reg_data = 9'h1F0;
    cmd_valid    = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (w = 0; w < 200; w++) begin
      @(negedge clk);
      if (obs.size() >= 2) break;
    end
    checkOutput("rst_reached_b1", int'(obs.size() >= 2), 1);
    @(posedge clk); @(posedge clk); @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rst_eng_op", eng_op, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready", cmd_ready, 1);
    checkOutput("rst_wdata", eng_wdata, 0);
    run_q.delete();
    acc_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    d0 = done_cnt;
    repeat (80) @(posedge clk);
    #1;
    checkOutput("no_done_after_rst", done_cnt - d0, 0);
  endtask

  initial begin
    logic [11:0] a;
    int k;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_dev_addr = 7'd0;
    cmd_reg_addr = 7'd0;
    cmd_reg_data = 9'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("idle_ready", cmd_ready, 1);
      checkOutput("idle_eng_op", eng_op, 0);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_done", done, 0);
    end
    checkOutput("idle_wdata", eng_wdata, 0);
    @(posedge clk);
    #1;

    $display("[TB] directed: full ACK write");
    applyStimulus(7'h1A, 7'h06, 9'h1F0, 12'hFFF);
    cmd_valid = 1'b0;
    waitDrain();

    $display("[TB] directed: NACK on second byte");
    applyStimulus(7'h1A, 7'h06, 9'h1F0, 12'hFFD);
    cmd_valid = 1'b0;
    waitDrain();

    $display("[TB] directed: back-to-back commands");
    applyStimulus(7'h1A, 7'h06, 9'h1F0, 12'hFFF);
    applyStimulus(7'h55, 7'h2B, 9'h0A5, 12'hFFF);
    cmd_valid = 1'b0;
    waitDrain();

    $display("[TB] directed: async reset mid-transfer");
    resetMidXfer();
    applyStimulus(7'h3C, 7'h11, 9'h123, 12'hFFF);
    cmd_valid = 1'b0;
    waitDrain();

`ifdef CODEC_I2C_RETRY_EN
    $display("[TB] directed: retry then success");
    applyStimulus(7'h1A, 7'h06, 9'h1F0, 12'hFFC);
    cmd_valid = 1'b0;
    waitDrain();
    $display("[TB] directed: retries exhausted");
    applyStimulus(7'h1A, 7'h06, 9'h1F0, 12'h000);
    cmd_valid = 1'b0;
    waitDrain();
`endif

    $display("[TB] random commands");
    for (int n = 0; n < 24; n++) begin
      for (int j = 0; j < 12; j++) a[j] = ($urandom_range(3, 0) != 0);
      applyStimulus(7'($urandom), 7'($urandom), 9'($urandom), a);
      if ($urandom_range(2, 0) != 0) begin
        cmd_valid = 1'b0;
        k = $urandom_range(3, 0);
        repeat (k) begin
          @(posedge clk);
          #1;
        end
      end
    end
    cmd_valid = 1'b0;
    waitDrain();

    checkOutput("scoreboard_empty", exp_nack_q.size(), 0);
    checkOutput("ack_plan_consumed", run_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/codec_i2c_seq.md
Name: codec_i2c_seq

Overview:
Command sequencer sitting directly upstream of the codec I2C byte engine. It accepts one codec register-write command (7-bit device address, 7-bit register address, 9-bit data). It breaks the command into three bytes, drives the engine's op/wdata pins byte by byte, and collects the engine's ack pulse. Status (done/nack) goes back to the codec configuration logic.

Parameters:
C_CLK_DIVISOR, 16'd2, sysclk cycles per SCL period; must equal the engine's divisor.
C_GAP_CYCLES, 16'd4, idle cycles (op=IDLE) inserted after every transaction, min 1.
C_MAX_RETRY, 2'd3, extra attempts after NACK; used only with the optional feature.

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  high when the sequencer can accept (state IDLE)
cmd_dev_addr  in  7  I2C device address
cmd_reg_addr  in  7  codec register address
cmd_reg_data  in  9  codec register data
eng_op  out  2  engine opcode: 0 idle, 1 write (2 never driven)
eng_wdata  out  8  byte to engine, bit-reversed
eng_ack  in  1  engine ack pulse (1 cycle, high = slave ACK)
busy  out  1  transaction in progress
done  out  1  1-cycle pulse: transaction finished (ACK or NACK)
nack  out  1  1-cycle pulse coincident with done when any byte NACKed

Behaviour:
- Reset (async): state IDLE, eng_op=0, eng_wdata=0, busy=0, done=0, nack=0, counters 0. cmd_ready=1 after reset.
- cmd_ready = (state==IDLE), combinational from state. Accept on clk edge with cmd_valid&&cmd_ready; latch all cmd fields; they are ignored thereafter until the next IDLE.
- Byte list: B0={dev_addr,1'b0}, B1={reg_addr,reg_data[8]}, B2=reg_data[7:0].
- eng_wdata = bit-reverse of current byte (engine shifts LSB first; this puts MSB on the wire first).
- FSM states:
  - IDLE -> LOAD on accept.
  - LOAD: 1 cycle, eng_op=0, eng_wdata=reversed byte[idx], ack_seen cleared -> XFER.
  - XFER: eng_op=1 for exactly 9*C_CLK_DIVISOR cycles (8 data + 1 ack slot). ack_seen set if eng_ack=1 on any cycle in XFER.
  - At the last XFER cycle: if ack_seen or eng_ack and idx<2 -> idx++, go to LOAD; if ack and idx==2 -> GAP; if no ack -> set nack_flag, go to GAP (abort remaining bytes).
  - GAP: eng_op=0, eng_wdata held, C_GAP_CYCLES cycles -> IDLE.
- done/nack registered, high only in the first IDLE cycle after GAP. Full ACK transaction: done high exactly 3*(1+9*C_CLK_DIVISOR)+C_GAP_CYCLES clocks after the accepting edge (61 with defaults).
- busy = state!=IDLE (registered-equivalent), 0 in the done cycle.
- XFER cycle counter is 20 bits wide (covers 9*65535). Byte idx is 2 bits. No wrap: idx is cleared on accept.
- eng_ack outside XFER is ignored.
- A new cmd_valid is accepted in the same cycle that done is high.
- Reset mid-transaction: immediate return to reset values. No done/nack is issued for the aborted command.

Optional Feature:
CODEC_I2C_RETRY_EN
- Defined: a NACK routes to GAP, then back to LOAD with idx=0 instead of IDLE, while retry_cnt<C_MAX_RETRY. retry_cnt is cleared on accept and incremented per retry. done pulses once, at final success or at exhaustion; nack=1 only if the final attempt NACKed. busy stays high throughout.
- Undefined: no retry logic or counter; a NACK ends the transaction as described above.

Test Plan:
- Reset then idle: cmd_ready=1, eng_op=0, busy=0, done=0 for 20 cycles.
- cmd dev=0x1A reg=0x06 data=0x1F0, eng_ack pulsed in every ack slot -> eng_wdata sequence 0x2C, 0xB0, 0x0F; each byte has eng_op=1 for 18 cycles; done=1, nack=0 at 61 clocks after accept.
- Same cmd, no ack on B1 -> B2 never loaded; done=1, nack=1 at 2*19+4=42 clocks after accept.
- Back-to-back: cmd_valid held high with a second command -> second accept in the done cycle; second B0 LOAD on the next cycle.
- Async rst asserted mid-XFER of B1 -> eng_op=0 and busy=0 without a clock edge; no done after release; next cmd runs normally.
- With CODEC_I2C_RETRY_EN, NACK on B0 for the first 2 attempts, ACK after -> 3 full B0 loads, single done with nack=0. All-NACK -> 4 attempts, then done=1, nack=1.
